// File: rtl/multicycle_alu.sv
// Single-issue ALU: logic/arith/shift ops finish after one EXEC cycle, while MUL
// runs an iterative shift-add over WIDTH cycles. Results and flags stay registered.
module multicycle_alu #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_LSL   = 4'b1000;
  localparam logic [3:0] OP_LSR   = 4'b1001;
  localparam logic [3:0] OP_ASR   = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [SHW-1:0]   cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] busw_q;
  logic             zero_q;
  logic             neg_q;
  logic             carry_q;
  logic             ovf_q;

  logic             is_sub;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;
  logic [WIDTH-1:0] mul_acc_d;

  // SUB is A + ~B + 1, so the carry-out is the inverted borrow.
  always_comb begin
    is_sub  = (op_q == OP_SUB);
    opb     = is_sub ? ~b_q : b_q;
    sum     = {1'b0, a_q} + {1'b0, opb} + {{WIDTH{1'b0}}, is_sub};
    shamt   = b_q[SHW-1:0];
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op_q)
      OP_AND:   res_d = a_q & b_q;
      OP_OR:    res_d = a_q | b_q;
      OP_XOR:   res_d = a_q ^ b_q;
      OP_PASSB: res_d = b_q;
      OP_ADD, OP_SUB: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (a_q[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_LSL:   res_d = a_q << shamt;
      OP_LSR:   res_d = a_q >> shamt;
      OP_ASR:   res_d = $signed(a_q) >>> shamt;
      default:  res_d = '0;
    endcase
  end

  // Multiplicand shifts left in a_q, multiplier shifts right in b_q.
  always_comb begin
    mul_acc_d = b_q[0] ? (acc_q + a_q) : acc_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      busw_q  <= '0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (Start) begin
            a_q     <= BusA;
            b_q     <= BusB;
            op_q    <= ALUCtrl;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (ALUCtrl == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          busw_q  <= res_d;
          zero_q  <= (res_d == '0);
          neg_q   <= res_d[WIDTH-1];
          carry_q <= carry_d;
          ovf_q   <= ovf_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        MUL: begin
          acc_q <= mul_acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            busw_q  <= mul_acc_d;
            zero_q  <= (mul_acc_d == '0);
            neg_q   <= mul_acc_d[WIDTH-1];
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign BusW     = busw_q;
  assign Zero     = zero_q;
  assign Negative = neg_q;
  assign Carry    = carry_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: table of vectors scored through a result queue on the
// 64-bit instance, plus directed MUL/reset sequences and an 8-bit instance.
module tb_multicycle_alu;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_LSL   = 4'b1000;
  localparam logic [3:0] OP_LSR   = 4'b1001;
  localparam logic [3:0] OP_ASR   = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;
  localparam int W  = 64;
  localparam int NV = 20;

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] w;
    logic        z, n, c, v;
  } vec_t;

  typedef struct {
    logic [63:0] w;
    logic        z, n, c, v;
    int          t0;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset, Start;
  logic [3:0]  ALUCtrl;
  logic [63:0] BusA, BusB, BusW;
  logic        Busy, Done, Zero, Negative, Carry, Overflow;

  logic        Start8;
  logic [3:0]  Op8;
  logic [7:0]  A8, B8, W8;
  logic        Busy8, Done8, Z8, N8, C8, V8;

  int          cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          busy_run = 0;
  int          last_busy_run = 0;
  logic        prev_done = 1'b0;
  logic [63:0] last_w = '0;
  exp_t        q[$];
  vec_t        vt[NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_alu u_dut (
    .Clk(clk), .Reset(Reset), .Start(Start), .ALUCtrl(ALUCtrl),
    .BusA(BusA), .BusB(BusB), .Busy(Busy), .Done(Done), .BusW(BusW),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow)
  );

  multicycle_alu #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Reset(Reset), .Start(Start8), .ALUCtrl(Op8),
    .BusA(A8), .BusB(B8), .Busy(Busy8), .Done(Done8), .BusW(W8),
    .Zero(Z8), .Negative(N8), .Carry(C8), .Overflow(V8)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic score();
    exp_t e;
    chk("done_not_back_to_back", 64'(prev_done), 64'(0));
    chk("done_expected", 64'(q.size() != 0), 64'(1));
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("busw", BusW, e.w);
      chk("zero", 64'(Zero), 64'(e.z));
      chk("negative", 64'(Negative), 64'(e.n));
      chk("carry", 64'(Carry), 64'(e.c));
      chk("overflow", 64'(Overflow), 64'(e.v));
      chk("latency", 64'(cyc - e.t0), 64'(e.lat));
      last_w = e.w;
    end
  endtask

  always @(negedge clk) begin
    if (Busy) busy_run <= busy_run + 1;
    else if (busy_run != 0) begin
      last_busy_run <= busy_run;
      busy_run      <= 0;
    end
    if (Done) score();
    prev_done <= Done;
  end

  // Drives one launch at the current time and scrambles inputs after acceptance.
  task automatic launch(input vec_t v);
    Start   = 1'b1;
    ALUCtrl = v.op;
    BusA    = v.a;
    BusB    = v.b;
    q.push_back('{w: v.w, z: v.z, n: v.n, c: v.c, v: v.v, t0: cyc,
                  lat: (v.op == OP_MUL) ? W + 1 : 2});
    @(negedge clk);
    Start   = 1'b0;
    ALUCtrl = ~v.op;
    BusA    = ~v.a;
    BusB    = ~v.b;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      if (q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    chk("drain", 64'(q.size()), 64'(0));
    q.delete();
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] w, input logic z, input logic n, input logic c,
                      input logic v, input int lat);
    int t0;
    bit seen;
    Start8 = 1'b1;
    Op8    = op;
    A8     = a;
    B8     = b;
    t0     = cyc;
    seen   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      Start8 = 1'b0;
      if (Done8) begin
        seen = 1'b1;
        break;
      end
    end
    chk("w8_done_seen", 64'(seen), 64'(1));
    chk("w8_latency", 64'(cyc - t0), 64'(lat));
    chk("w8_busw", 64'(W8), 64'(w));
    chk("w8_zero", 64'(Z8), 64'(z));
    chk("w8_negative", 64'(N8), 64'(n));
    chk("w8_carry", 64'(C8), 64'(c));
    chk("w8_overflow", 64'(V8), 64'(v));
  endtask

  initial begin
    vt[0]  = '{OP_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{OP_SUB,   64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[2]  = '{OP_ASR,   64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{OP_LSR,   64'h8000_0000_0000_0000, 64'h43, 64'h1000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{OP_AND,   64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{OP_OR,    64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{OP_XOR,   64'hFF, 64'h0F, 64'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{OP_PASSB, 64'h1234, 64'hDEAD_BEEF_0000_0000, 64'hDEAD_BEEF_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{OP_LSL,   64'h1, 64'h3F, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{OP_LSL,   64'h5, 64'h100, 64'h5, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{OP_SUB,   64'h5, 64'h5, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[11] = '{OP_SUB,   64'h3, 64'h5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[12] = '{OP_ADD,   64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[13] = '{4'b0100,  64'hFF, 64'hFF, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[14] = '{OP_ASR,   64'h4000_0000_0000_0000, 64'h2, 64'h1000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[15] = '{OP_MUL,   64'h3, 64'h5, 64'hF, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[16] = '{OP_MUL,   64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[17] = '{4'b1111,  64'h7, 64'h7, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[18] = '{OP_ADD,   64'h5, 64'h7, 64'hC, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[19] = '{OP_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h1, 1'b0, 1'b0, 1'b1, 1'b0};

    Reset = 1'b1; Start = 1'b0; ALUCtrl = '0; BusA = '0; BusB = '0;
    Start8 = 1'b0; Op8 = '0; A8 = '0; B8 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busw", BusW, 64'h0);
    chk("rst_zero", 64'(Zero), 64'(1));
    chk("rst_negative", 64'(Negative), 64'(0));
    chk("rst_carry", 64'(Carry), 64'(0));
    chk("rst_overflow", 64'(Overflow), 64'(0));
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_done", 64'(Done), 64'(0));
    chk("rst8_zero", 64'(Z8), 64'(1));
    Reset = 1'b0;

    // Each launch lands in the DONE cycle of the previous op (back-to-back).
    for (int i = 0; i < NV; i++) begin
      launch(vt[i]);
      wait_idle();
    end

    // Long MUL with a stray Start mid-flight; previous result must hold.
    launch(vt[16]);
    repeat (8) @(negedge clk);
    #1;
    Start = 1'b1; ALUCtrl = OP_ADD; BusA = 64'h1; BusB = 64'h1;
    @(negedge clk);
    #1;
    Start = 1'b0;
    chk("busw_hold_during_mul", BusW, last_w);
    chk("busy_during_mul", 64'(Busy), 64'(1));
    wait_idle();
    chk("mul_busy_cycles", 64'(last_busy_run), 64'(W));

    // Reset mid-MUL aborts without Done or result write.
    launch(vt[15]);
    repeat (17) @(negedge clk);
    #1;
    Reset = 1'b1;
    q.delete();
    @(negedge clk);
    #1;
    Reset = 1'b0;
    chk("abort_busw", BusW, 64'h0);
    chk("abort_zero", 64'(Zero), 64'(1));
    chk("abort_busy", 64'(Busy), 64'(0));
    chk("abort_done", 64'(Done), 64'(0));
    repeat (70) @(negedge clk);
    #1;
    launch(vt[4]);
    wait_idle();

    // Reset wins over a simultaneous Start; next Start is accepted normally.
    Reset = 1'b1; Start = 1'b1; ALUCtrl = OP_ADD; BusA = 64'h1; BusB = 64'h1;
    @(negedge clk);
    #1;
    Reset = 1'b0; Start = 1'b0;
    chk("rst_prio_busy", 64'(Busy), 64'(0));
    chk("rst_prio_busw", BusW, 64'h0);
    repeat (3) @(negedge clk);
    #1;
    launch(vt[5]);
    wait_idle();

    run8(OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 2);
    run8(OP_MUL, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 9);
    run8(OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    run8(OP_MUL, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b1, 1'b0, 1'b0, 9);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHW, default log2(WIDTH): width of the shift-amount field taken from BusB[SHW-1:0].
REQ-003 Clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Reset  input  1: synchronous, active-high reset.
REQ-005 Start  input  1: request to launch an operation.
REQ-006 ALUCtrl  input  4: operation select.
REQ-007 BusA  input  WIDTH: operand A.
REQ-008 BusB  input  WIDTH: operand B.
REQ-009 Busy  output  1: high while an operation is in flight.
REQ-010 Done  output  1: one-cycle pulse marking the cycle in which the result becomes valid.
REQ-011 BusW  output  WIDTH: registered result.
REQ-012 Zero  output  1: registered flag, set when BusW is all zeros.
REQ-013 Negative  output  1: registered flag, equal to BusW[WIDTH-1].
REQ-014 Carry  output  1: registered carry-out for ADD; NOT borrow for SUB; 0 for all other ops.
REQ-015 Overflow  output  1: registered signed overflow for ADD and SUB; 0 for all other ops.

Function
REQ-016 ALUCtrl encodings:
- AND = 0000
- OR = 0001
- ADD = 0010
- XOR = 0011
- SUB = 0110
- PassB = 0111
- LSL = 1000
- LSR = 1001
- ASR = 1010
- MUL = 1011
REQ-017 Any other encoding produces BusW = 0 with single-cycle latency; the resulting flags are Zero = 1 and all other flags 0.
REQ-018 FSM states are IDLE, EXEC, MUL and DONE.
REQ-019 A launch is accepted only when Start = 1 in a cycle where Busy = 0.
- BusA, BusB and ALUCtrl are captured into internal registers at acceptance.
- Inputs are don't-care after acceptance.
REQ-020 Start asserted while Busy = 1 is ignored; no queuing.
REQ-021 Single-cycle ops (everything except MUL) go IDLE -> EXEC -> DONE.
- The result is written at the end of EXEC.
- Done = 1 during DONE, which is the second cycle after acceptance.
REQ-022 MUL goes IDLE -> MUL -> DONE.
- It is an iterative shift-add over exactly WIDTH cycles in state MUL.
- Done = 1 in cycle WIDTH+1 after acceptance.
REQ-023 The MUL result is the low WIDTH bits of the unsigned product.
REQ-024 Shifts use BusB[SHW-1:0] as the amount and ignore the upper bits of BusB.
- LSL and LSR fill with zeros.
- ASR fills with BusA[WIDTH-1].
- A shift amount of 0 returns BusA.
REQ-025 ADD and SUB are computed at WIDTH+1 bits to derive Carry.
- Overflow = (sign A == sign of operand-as-added) AND (sign result != sign A).
REQ-026 Busy = 1 in the EXEC and MUL states and 0 in the IDLE and DONE states.
- A new Start is therefore accepted in the DONE cycle, giving back-to-back throughput of one op per two cycles for single-cycle ops.
REQ-027 BusW and all flags update only at result write.
- They hold their value across IDLE and across the execution of the next operation until that operation's own write.
REQ-028 Done returns to 0 the cycle after DONE unless the next operation completes in that cycle; it is never high for two consecutive cycles.

Reset
REQ-029 While Reset = 1 at a rising edge, the following outputs and state are cleared:
- FSM goes to IDLE.
- Busy = 0 and Done = 0.
- BusW = 0, Zero = 1, Negative = 0, Carry = 0, Overflow = 0.
- Internal operand, accumulator and counter registers are cleared.
REQ-030 Reset asserted mid-operation aborts that operation with no Done pulse and no result write.
REQ-031 Reset has priority over Start in the same cycle.
REQ-032 After Reset deasserts, the first edge with Start = 1 is accepted normally.

Verification (WIDTH = 64 unless stated)
REQ-033 ADD, BusA = 0xFFFFFFFFFFFFFFFF, BusB = 1 -> Done at cycle 2 with BusW = 0, Zero = 1, Carry = 1, Overflow = 0.
REQ-034 SUB, BusA = 0x8000000000000000, BusB = 1 -> BusW = 0x7FFFFFFFFFFFFFFF, Overflow = 1, Carry = 1, Negative = 0.
REQ-035 MUL, BusA = 0x00000000FFFFFFFF, BusB = 0x0000000100000001 -> Busy held for 64 cycles, Done at cycle 65, BusW = 0xFFFFFFFFFFFFFFFF; a Start pulse at cycle 10 is ignored.
REQ-036 ASR, BusA = 0x8000000000000000, BusB = 0x43 (amount 3) -> BusW = 0xF000000000000000, Negative = 1; LSR on the same inputs -> 0x1000000000000000.
REQ-037 MUL launched, Reset asserted at cycle 20 -> no Done pulse, BusW = 0, Zero = 1, Busy = 0 next cycle; a subsequent AND of 0xF0 with 0x3C -> BusW = 0x30.
REQ-038 WIDTH = 8: ADD 0x7F + 0x01 -> BusW = 0x80, Overflow = 1, Negative = 1; MUL 0x10 x 0x10 -> BusW = 0x00, Zero = 1, Done at cycle 9.
